// File: rtl/dr_sync_sink_if.sv
`default_nettype none
// ============================================================================
// Module   : dr_sync_sink_if
// Purpose  : Dual-rail channel plus decoded valid/ready token bus.
// Revision : 1.0 - initial release
// ============================================================================
interface dr_sync_sink_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0][1:0] in;
  logic                  ack_o;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  in,
    output ack_o,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in,
    input  ack_o,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/dr_sync_sink.sv
`default_nettype none
// ============================================================================
// Module   : dr_sync_sink
// Purpose  : Clocked receiver for a TP/FP dual-rail channel with valid/ready out.
// Revision : 1.0 - initial release
// ============================================================================
module dr_sync_sink #(
  parameter int          WIDTH       = 32,
  parameter logic [15:0] ENC         = "TP",
  parameter int          SYNC_STAGES = 2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  dr_sync_sink_if.slave    ch,
  output logic             err_o,
  output logic [15:0]      tok_cnt
);

  localparam bit c_fp = (ENC == "FP");

  typedef enum logic [0:0] {
    ST_WAIT_DATA = 1'b0,
    ST_WAIT_NULL = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0][1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0][1:0] r_hist;
  logic [WIDTH-1:0][1:0] r_s_prev;
  logic [WIDTH-1:0]      r_out_data;
  logic                  r_out_valid;
  logic                  r_ack;
  logic                  r_err;
  logic [15:0]           r_tok_cnt;

  logic [WIDTH-1:0][1:0] w_s;
  logic [WIDTH-1:0][1:0] w_d;
  logic [WIDTH-1:0]      w_bit_done;
  logic [WIDTH-1:0]      w_bit_bad;
  logic [WIDTH-1:0]      w_dec;
  logic                  w_word_done;
  logic                  w_word_bad;
  logic                  w_all_null;
  logic                  w_rail_rise;
  logic                  w_out_free;
  logic                  w_load;
  logic                  w_ack_clr;
  logic                  w_err_set;

  // Every rail passes through the synchronizer; nothing downstream sees ch.in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= ch.in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];
  assign w_d = c_fp ? w_s : (w_s ^ r_hist);

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign w_bit_done[i] = w_d[i][1] ^ w_d[i][0];
      assign w_bit_bad[i]  = w_d[i][1] & w_d[i][0];
      assign w_dec[i]      = w_d[i][1];
    end
  endgenerate

  assign w_word_done = &w_bit_done;
  assign w_word_bad  = |w_bit_bad;
  assign w_all_null  = ~|w_s;
  assign w_rail_rise = |(w_s & ~r_s_prev);
  assign w_out_free  = ~r_out_valid | ch.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WAIT_DATA;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ack_clr   = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_WAIT_DATA: begin
        if (w_word_bad) begin
          w_err_set = 1'b1;
        end else if (w_word_done && w_out_free) begin
          w_load = 1'b1;
          if (c_fp) begin
            w_state_nxt = ST_WAIT_NULL;
          end
        end
      end
      ST_WAIT_NULL: begin
        if (w_all_null) begin
          w_ack_clr   = 1'b1;
          w_state_nxt = ST_WAIT_DATA;
        end else if (w_rail_rise) begin
          w_err_set = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_WAIT_DATA;
      end
    endcase
  end

  // A load on the same edge as a drain keeps out_valid high with the new token.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist      <= '0;
      r_s_prev    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_tok_cnt   <= '0;
    end else begin
      r_s_prev <= w_s;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_load) begin
        r_out_data  <= w_dec;
        r_out_valid <= 1'b1;
        r_tok_cnt   <= r_tok_cnt + 16'd1;
        r_ack       <= c_fp ? 1'b1 : ~r_ack;
        if (!c_fp) begin
          r_hist <= w_s;
        end
      end else begin
        if (r_out_valid && ch.out_ready) begin
          r_out_valid <= 1'b0;
        end
        if (w_ack_clr) begin
          r_ack <= 1'b0;
        end
      end
    end
  end

  assign ch.ack_o     = r_ack;
  assign ch.out_data  = r_out_data;
  assign ch.out_valid = r_out_valid;
  assign err_o        = r_err;
  assign tok_cnt      = r_tok_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dr_sync_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_dr_sync_sink
// Purpose  : Directed bench for an FP 8-bit sink and a TP 32-bit Fibonacci link.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dr_sync_sink;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dr_sync_sink_if #(.WIDTH(8))  fp_ch ();
  dr_sync_sink_if #(.WIDTH(32)) tp_ch ();

  logic        fp_err;
  logic        tp_err;
  logic [15:0] fp_tok;
  logic [15:0] tp_tok;

  dr_sync_sink #(.WIDTH(8), .ENC("FP"), .SYNC_STAGES(2)) u_fp (
    .clk     (clk),
    .rst_n   (rst_n),
    .ch      (fp_ch),
    .err_o   (fp_err),
    .tok_cnt (fp_tok)
  );

  dr_sync_sink #(.WIDTH(32), .ENC("TP"), .SYNC_STAGES(2)) u_tp (
    .clk     (clk),
    .rst_n   (rst_n),
    .ch      (tp_ch),
    .err_o   (tp_err),
    .tok_cnt (tp_tok)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0][1:0] fp_rails(input logic [7:0] v);
    logic [7:0][1:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0][1:0]  r8;
    logic [31:0][1:0] tp_rails;
    logic [31:0]      v;
    logic             exp_ack;
    int               fib [7];

    fib = '{1, 1, 2, 3, 5, 8, 13};
    rst_n           = 1'b0;
    fp_ch.in        = '0;
    fp_ch.out_ready = 1'b1;
    tp_ch.in        = '0;
    tp_ch.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ack",   fp_ch.ack_o, 0);
    check("rst_valid", fp_ch.out_valid, 0);
    check("rst_data",  fp_ch.out_data, 0);
    check("rst_err",   fp_err, 0);
    check("rst_tok",   fp_tok, 0);
    check("rst_tp_ack", tp_ch.ack_o, 0);
    check("rst_tp_tok", tp_tok, 0);
    rst_n = 1'b1;
    edges(1);

    // FP single token with latency
    fp_ch.in = fp_rails(8'h2A);
    edges(2);
    check("fp_ack_early",   fp_ch.ack_o, 0);
    check("fp_valid_early", fp_ch.out_valid, 0);
    edges(1);
    check("fp_ack",   fp_ch.ack_o, 1);
    check("fp_valid", fp_ch.out_valid, 1);
    check("fp_data",  fp_ch.out_data, 8'h2A);
    check("fp_tok",   fp_tok, 1);
    edges(1);
    check("fp_consumed", fp_ch.out_valid, 0);
    fp_ch.in = '0;
    edges(2);
    check("fp_null_ack_early", fp_ch.ack_o, 1);
    edges(1);
    check("fp_null_ack", fp_ch.ack_o, 0);

    // FP skew: bits arrive one per cycle
    for (int i = 0; i < 7; i++) begin
      fp_ch.in[i] = 2'b10;
      edges(1);
    end
    check("skew_partial_ack", fp_ch.ack_o, 0);
    fp_ch.in[7] = 2'b10;
    edges(2);
    check("skew_ack_early", fp_ch.ack_o, 0);
    edges(1);
    check("skew_ack",  fp_ch.ack_o, 1);
    check("skew_data", fp_ch.out_data, 8'hFF);
    check("skew_tok",  fp_tok, 2);
    edges(1);
    fp_ch.in = '0;
    edges(3);
    check("skew_null_ack", fp_ch.ack_o, 0);

    // Backpressure
    fp_ch.out_ready = 1'b0;
    fp_ch.in = fp_rails(8'h11);
    edges(3);
    check("bp1_ack",   fp_ch.ack_o, 1);
    check("bp1_data",  fp_ch.out_data, 8'h11);
    check("bp1_valid", fp_ch.out_valid, 1);
    check("bp1_tok",   fp_tok, 3);
    fp_ch.in = '0;
    edges(3);
    check("bp1_null_ack", fp_ch.ack_o, 0);
    fp_ch.in = fp_rails(8'h22);
    edges(5);
    check("bp2_hold_ack",   fp_ch.ack_o, 0);
    check("bp2_hold_data",  fp_ch.out_data, 8'h11);
    check("bp2_hold_valid", fp_ch.out_valid, 1);
    check("bp2_hold_tok",   fp_tok, 3);
    fp_ch.out_ready = 1'b1;
    edges(1);
    check("bp2_ack",   fp_ch.ack_o, 1);
    check("bp2_valid", fp_ch.out_valid, 1);
    check("bp2_data",  fp_ch.out_data, 8'h22);
    check("bp2_tok",   fp_tok, 4);
    edges(1);
    check("bp2_consumed", fp_ch.out_valid, 0);
    fp_ch.in = '0;
    edges(3);
    check("bp2_null_ack", fp_ch.ack_o, 0);

    // Reset in the middle of a handshake
    fp_ch.out_ready = 1'b0;
    fp_ch.in = fp_rails(8'h33);
    edges(3);
    check("mid_pre_ack", fp_ch.ack_o, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack",   fp_ch.ack_o, 0);
    check("mid_rst_valid", fp_ch.out_valid, 0);
    check("mid_rst_tok",   fp_tok, 0);
    check("mid_rst_data",  fp_ch.out_data, 0);
    fp_ch.in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    fp_ch.out_ready = 1'b1;
    edges(1);
    fp_ch.in = fp_rails(8'h5A);
    edges(3);
    check("post_rst_data", fp_ch.out_data, 8'h5A);
    check("post_rst_ack",  fp_ch.ack_o, 1);
    check("post_rst_tok",  fp_tok, 1);
    edges(1);
    fp_ch.in = '0;
    edges(3);
    check("post_rst_null_ack", fp_ch.ack_o, 0);
    check("post_rst_err", fp_err, 0);

    // FP illegal codeword on bit 3
    r8 = fp_rails(8'h00);
    r8[3] = 2'b11;
    fp_ch.in = r8;
    edges(3);
    check("ill_err",   fp_err, 1);
    check("ill_ack",   fp_ch.ack_o, 0);
    check("ill_valid", fp_ch.out_valid, 0);
    edges(3);
    check("ill_hold_ack", fp_ch.ack_o, 0);
    check("ill_hold_tok", fp_tok, 1);
    fp_ch.in = '0;
    edges(3);
    check("ill_sticky", fp_err, 1);

    // TP Fibonacci link, 32 bits
    tp_rails = '0;
    exp_ack  = 1'b0;
    for (int k = 0; k < 7; k++) begin
      v = fib[k];
      for (int i = 0; i < 32; i++) begin
        if (v[i]) tp_rails[i][1] = ~tp_rails[i][1];
        else      tp_rails[i][0] = ~tp_rails[i][0];
      end
      tp_ch.in = tp_rails;
      if (k == 0) begin
        edges(2);
        check("tp_ack_early", tp_ch.ack_o, 0);
        edges(1);
      end else begin
        edges(3);
      end
      exp_ack = ~exp_ack;
      check("tp_data",  tp_ch.out_data, v);
      check("tp_ack",   tp_ch.ack_o, exp_ack);
      check("tp_valid", tp_ch.out_valid, 1);
      check("tp_tok",   tp_tok, k + 1);
      edges(1);
      check("tp_consumed", tp_ch.out_valid, 0);
    end
    check("tp_err", tp_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
